fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage for the pipelined datapath. It takes the current `PC` and the instruction word read at that address, and computes the next `Address` that drives the program counter register. It also holds the IF/ID pipeline register with stall, flush and post-reset bubble handling. It sits between the program counter and instruction memory on one side and the decode stage on the other.

## Interface
- `NOP_WORD`, default 32'h0000_0000: instruction injected on a bubble or flush.
- `FLUSH_CNT_W`, default 8: width of the saturating flush counter.

Ports:
- `Clk`  in  1  clock; all registers update on the rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `PC`  in  32  current program counter value.
- `Instruction`  in  32  instruction memory read data at `PC` (combinational read).
- `Stall`  in  1  hazard-unit hold request.
- `BranchTaken`  in  1  branch resolved taken this cycle.
- `BranchTarget`  in  32  byte address of the branch target.
- `Jump`  in  1  jump resolved this cycle.
- `JumpTarget`  in  32  byte address of the jump target.
- `Address`  out  32  next-PC value to the program counter (combinational).
- `IF_ID_Instruction`  out  32  registered instruction.
- `IF_ID_PCPlus4`  out  32  registered `PC`+4.
- `IF_ID_Valid`  out  1  registered; 1 means the IF/ID contents are a real instruction.
- `FlushCount`  out  `FLUSH_CNT_W`  number of flush cycles, saturating.

## Operation
- `PCPlus4` = `PC` + 4, 32-bit modular (0xFFFF_FFFC wraps to 0).
- `Redirect` = `Jump` | `BranchTaken`.
- `Warm` flag:
  - Set by `Reset`.
  - Cleared on the first rising edge after `Reset` deasserts.
  - Matches the program counter's one-cycle post-reset hold.
- `Address` priority, highest first:
  - `Warm` → `PC`.
  - `Jump` → {`JumpTarget`[31:2], 2'b00}.
  - `BranchTaken` → {`BranchTarget`[31:2], 2'b00}.
  - `Stall` → `PC`.
  - otherwise → `PCPlus4`.
- Redirect beats stall: a redirect with `Stall`=1 still redirects and flushes.
- Out-of-range addresses are not checked here; the program counter wraps them.
- IF/ID register update on each edge, highest priority first:
  - `Warm` → load `NOP_WORD`, PC+4 field 0, `Valid`=0. This is the bubble that absorbs the duplicate fetch at address 0.
  - `Redirect` → load `NOP_WORD`, PC+4 field 0, `Valid`=0. This is a flush.
  - `Stall` → hold all three fields.
  - otherwise → load `Instruction`, `PCPlus4`, `Valid`=1.
- `FlushCount`:
  - Increments on every edge where `Redirect`=1 and `Warm`=0.
  - Saturates at all-ones.
- Reset values: `IF_ID_Instruction`=`NOP_WORD`, `IF_ID_PCPlus4`=0, `IF_ID_Valid`=0, `FlushCount`=0, `Warm`=1.
- Reset mid-operation: every register returns to its reset value immediately (asynchronous), regardless of `Stall` or `Redirect`.

## Timing
- `Address` is combinational from `PC`, the control inputs and `Warm`, with zero-cycle latency. It must settle before the program counter's rising edge.
- IF/ID has one-cycle latency. The instruction fetched at `PC` in cycle N appears on the `IF_ID_*` outputs in cycle N+1.
- Branch or jump penalty is exactly one bubble. The target's instruction appears on IF/ID two edges after `Redirect` is sampled.
- A stall of K cycles holds both `Address`=`PC` and IF/ID for K edges. Fetch resumes with `PCPlus4` on the first edge with `Stall`=0.
- After `Reset` deasserts:
  - Edge 1: bubble, `Warm` clears.
  - Edge 2: captures the instruction at 0 with `Valid`=1.
  - `Address` equals 0, 0, then 4 across those cycles.

## Structure
- Shared package `fetch_pkg`:
  - `NOP_WORD` default.
  - `PC_STEP`=4.
  - A 3-field struct type for the IF/ID payload (instruction, pc_plus4, valid).
- One sub-module, `if_id_reg`:
  - Async-reset payload register with `load`, `flush` and `hold` controls.
- The parent holds the next-PC mux, the `Warm` flag and `FlushCount`.

## Test plan
- Reset then run: release `Reset`, `Instruction`=0x2008_0005 at PC 0. Required: `Valid`=0 at edge 1, then `IF_ID_Instruction`=0x2008_0005 with `IF_ID_PCPlus4`=4 at edge 2, and `Address` sequence 0, 0, 4.
- Sequential fetch: `PC`=0x10. Required: `Address`=0x14; the next edge loads `IF_ID_PCPlus4`=0x14, `Valid`=1.
- Taken branch: `BranchTaken`=1, `BranchTarget`=0x43. Required: `Address`=0x40; the next edge gives `IF_ID_Valid`=0, instruction 0, and `FlushCount` increments by 1.
- Stall: `Stall`=1 for 3 cycles at `PC`=0x20. Required: `Address`=0x20 throughout, IF/ID unchanged; `Address`=0x24 once `Stall` drops.
- Jump during stall: `Stall`=1, `Jump`=1, `JumpTarget`=0x8, `BranchTaken`=1. Required: `Address`=0x8 (jump wins) and IF/ID flushed.
- Saturation and async reset: 300 consecutive redirects. Required: `FlushCount`=255. Then assert `Reset` between edges. Required: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID payload register: flush injects a bubble, hold freezes, load captures.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   load,
  input  logic   flush,
  input  logic   hold,
  input  if_id_t d,
  output if_id_t q
);
  if_id_t bubble;
  assign bubble = '{instruction: NOP_WORD, pc_plus4: 32'd0, valid: 1'b0};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)          q <= bubble;
    else if (flush)     q <= bubble;
    else if (hold)      q <= q;
    else if (load)      q <= d;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC select, post-reset warm bubble, IF/ID register
// and a saturating count of redirect flushes.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEF,
  parameter int          FLUSH_CNT_W = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [31:0]            PC,
  input  logic [31:0]            Instruction,
  input  logic                   Stall,
  input  logic                   BranchTaken,
  input  logic [31:0]            BranchTarget,
  input  logic                   Jump,
  input  logic [31:0]            JumpTarget,
  output logic [31:0]            Address,
  output logic [31:0]            IF_ID_Instruction,
  output logic [31:0]            IF_ID_PCPlus4,
  output logic                   IF_ID_Valid,
  output logic [FLUSH_CNT_W-1:0] FlushCount
);
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        warm;
  if_id_t      d, q;

  assign pc_plus4 = PC + PC_STEP;
  assign redirect = Jump | BranchTaken;

  // Warm mirrors the PC register's one-cycle hold after reset release.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) warm <= 1'b1;
    else       warm <= 1'b0;
  end

  always_comb begin
    Address = pc_plus4;
    if (warm)             Address = PC;
    else if (Jump)        Address = {JumpTarget[31:2], 2'b00};
    else if (BranchTaken) Address = {BranchTarget[31:2], 2'b00};
    else if (Stall)       Address = PC;
  end

  assign d = '{instruction: Instruction, pc_plus4: pc_plus4, valid: 1'b1};

  if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (~Stall),
    .flush (warm | redirect),
    .hold  (Stall),
    .d     (d),
    .q     (q)
  );

  assign IF_ID_Instruction = q.instruction;
  assign IF_ID_PCPlus4     = q.pc_plus4;
  assign IF_ID_Valid       = q.valid;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      FlushCount <= '0;
    else if (redirect && !warm && (FlushCount != {FLUSH_CNT_W{1'b1}}))
      FlushCount <= FlushCount + 1'b1;
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PC, Instruction, BranchTarget, JumpTarget;
  logic        Stall, BranchTaken, Jump;
  logic [31:0] Address, IF_ID_Instruction, IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [7:0]  FlushCount;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .PC(PC), .Instruction(Instruction),
    .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .Address(Address),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; PC = 32'h0; Instruction = 32'h2008_0005;
    Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
    Jump = 1'b0; JumpTarget = 32'h0;
    step(); step();
    chk("rst_instr", IF_ID_Instruction, 32'h0);
    chk("rst_pc4",   IF_ID_PCPlus4, 32'h0);
    chk("rst_valid", {31'b0, IF_ID_Valid}, 32'h0);
    chk("rst_fcnt",  {24'b0, FlushCount}, 32'h0);
    chk("rst_addr",  Address, 32'h0);

    // Reset release: Address 0, 0, 4; bubble then first real fetch.
    Reset = 1'b0; #1;
    chk("warm_addr", Address, 32'h0);
    step();
    chk("e1_valid", {31'b0, IF_ID_Valid}, 32'h0);
    chk("e1_addr",  Address, 32'h4);
    step();
    chk("e2_instr", IF_ID_Instruction, 32'h2008_0005);
    chk("e2_pc4",   IF_ID_PCPlus4, 32'h4);
    chk("e2_valid", {31'b0, IF_ID_Valid}, 32'h1);

    // Sequential fetch.
    PC = 32'h10; Instruction = 32'h1234_5678; #1;
    chk("seq_addr", Address, 32'h14);
    step();
    chk("seq_pc4",   IF_ID_PCPlus4, 32'h14);
    chk("seq_instr", IF_ID_Instruction, 32'h1234_5678);
    chk("seq_valid", {31'b0, IF_ID_Valid}, 32'h1);

    // Taken branch, target low bits masked.
    PC = 32'h14; BranchTaken = 1'b1; BranchTarget = 32'h43; #1;
    chk("br_addr", Address, 32'h40);
    step();
    chk("br_valid", {31'b0, IF_ID_Valid}, 32'h0);
    chk("br_instr", IF_ID_Instruction, 32'h0);
    chk("br_fcnt",  {24'b0, FlushCount}, 32'h1);
    BranchTaken = 1'b0; PC = 32'h40; Instruction = 32'hAAAA_0001;
    step();
    chk("tgt_instr", IF_ID_Instruction, 32'hAAAA_0001);
    chk("tgt_pc4",   IF_ID_PCPlus4, 32'h44);
    chk("tgt_valid", {31'b0, IF_ID_Valid}, 32'h1);

    // Three-cycle stall holds Address and IF/ID.
    PC = 32'h20; Instruction = 32'hDEAD_BEEF; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stl_addr", Address, 32'h20);
      step();
      chk("stl_instr", IF_ID_Instruction, 32'hAAAA_0001);
      chk("stl_pc4",   IF_ID_PCPlus4, 32'h44);
      chk("stl_valid", {31'b0, IF_ID_Valid}, 32'h1);
    end
    Stall = 1'b0; #1;
    chk("unstl_addr", Address, 32'h24);
    step();
    chk("unstl_pc4",   IF_ID_PCPlus4, 32'h24);
    chk("unstl_instr", IF_ID_Instruction, 32'hDEAD_BEEF);

    // Jump beats branch and stall.
    Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h8;
    BranchTaken = 1'b1; BranchTarget = 32'h100; #1;
    chk("jmp_addr", Address, 32'h8);
    step();
    chk("jmp_valid", {31'b0, IF_ID_Valid}, 32'h0);
    chk("jmp_instr", IF_ID_Instruction, 32'h0);
    chk("jmp_pc4",   IF_ID_PCPlus4, 32'h0);
    chk("jmp_fcnt",  {24'b0, FlushCount}, 32'h2);

    // Saturation: 300 more redirects from a count of 2.
    Stall = 1'b0; BranchTaken = 1'b0;
    for (int i = 0; i < 252; i++) step();
    chk("fcnt_254", {24'b0, FlushCount}, 32'd254);
    for (int i = 0; i < 48; i++) step();
    chk("fcnt_sat", {24'b0, FlushCount}, 32'd255);

    // Load a real instruction, then assert Reset between edges.
    Jump = 1'b0; PC = 32'h30; Instruction = 32'h0BAD_F00D;
    step();
    chk("pre_valid", {31'b0, IF_ID_Valid}, 32'h1);
    #2 Reset = 1'b1; Stall = 1'b1; Jump = 1'b1; #1;
    chk("arst_instr", IF_ID_Instruction, 32'h0);
    chk("arst_pc4",   IF_ID_PCPlus4, 32'h0);
    chk("arst_valid", {31'b0, IF_ID_Valid}, 32'h0);
    chk("arst_fcnt",  {24'b0, FlushCount}, 32'h0);
    chk("arst_addr",  Address, 32'h30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
